// File: rtl/pmu_acs_if.sv
// Bundles the branch-metric inputs and path-metric outputs of the Viterbi path metric unit.
interface pmu_acs_if #(
  parameter int PM_W = 4
);
  // bm_valid has no ready: the PMU accepts one trellis step on every edge where it is high.
  // dec_valid pulses for exactly the cycle after an accepted step; dec/pm/best_state are
  // stable between pulses. start overrides bm_valid and discards that cycle's metrics.
  logic            start;
  logic            bm_valid;
  logic [1:0]      s0_00, s0_01, s1_10, s1_11;
  logic [1:0]      s2_00, s2_01, s3_10, s3_11;
  logic [3:0]      dec;
  logic            dec_valid;
  logic [PM_W-1:0] pm0, pm1, pm2, pm3;
  logic [1:0]      best_state;
  logic            tb_ready;

  modport master (
    output start, bm_valid, s0_00, s0_01, s1_10, s1_11, s2_00, s2_01, s3_10, s3_11,
    input  dec, dec_valid, pm0, pm1, pm2, pm3, best_state, tb_ready
  );

  modport slave (
    input  start, bm_valid, s0_00, s0_01, s1_10, s1_11, s2_00, s2_01, s3_10, s3_11,
    output dec, dec_valid, pm0, pm1, pm2, pm3, best_state, tb_ready
  );
endinterface

// File: rtl/pmu_acs.sv
// Add-compare-select path metric unit for the 4-state K=3 Viterbi decoder.
// Define PMU_NORM_EN to subtract the minimum selected metric after each step.
module pmu_acs #(
  parameter int PM_W     = 4,
  parameter int INIT_PM  = 4,
  parameter int TB_DEPTH = 15
) (
  input logic       clk,
  input logic       rst_n,
  pmu_acs_if.slave  bus
);
  localparam int              CNT_W   = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W:0]   PM_MAX  = {1'b0, {PM_W{1'b1}}};
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(INIT_PM);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TB_DEPTH);

  logic [PM_W-1:0]  pm_q [4];
  logic [PM_W-1:0]  pm_d [4];
  logic [3:0]       dec_q, dec_d;
  logic             dec_valid_q, dec_valid_d;
  logic [1:0]       best_q, best_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, rdy_d;

  logic [1:0]       bm_lo [4];
  logic [1:0]       bm_hi [4];
  logic [PM_W:0]    cand_lo [4];
  logic [PM_W:0]    cand_hi [4];
  logic [PM_W:0]    sel [4];
  logic [PM_W:0]    norm [4];
  logic [PM_W-1:0]  new_pm [4];
  logic [3:0]       dec_acs;
  logic [1:0]       best_n;
`ifdef PMU_NORM_EN
  logic [PM_W:0]    sel_min;
`endif

  // State n's predecessors are n/2 (lower) and n/2+2 (upper).
  always_comb begin
    bm_lo[0] = bus.s0_00; bm_hi[0] = bus.s2_00;
    bm_lo[1] = bus.s0_01; bm_hi[1] = bus.s2_01;
    bm_lo[2] = bus.s1_10; bm_hi[2] = bus.s3_10;
    bm_lo[3] = bus.s1_11; bm_hi[3] = bus.s3_11;
    dec_acs  = '0;
    for (int n = 0; n < 4; n++) begin
      cand_lo[n] = {1'b0, pm_q[n/2]}     + (PM_W+1)'(bm_lo[n]);
      cand_hi[n] = {1'b0, pm_q[n/2 + 2]} + (PM_W+1)'(bm_hi[n]);
      dec_acs[n] = (cand_hi[n] < cand_lo[n]);
      sel[n]     = dec_acs[n] ? cand_hi[n] : cand_lo[n];
    end
`ifdef PMU_NORM_EN
    sel_min = sel[0];
    for (int n = 1; n < 4; n++) begin
      if (sel[n] < sel_min) sel_min = sel[n];
    end
    for (int n = 0; n < 4; n++) norm[n] = sel[n] - sel_min;
`else
    for (int n = 0; n < 4; n++) norm[n] = sel[n];
`endif
    for (int n = 0; n < 4; n++) begin
      new_pm[n] = (norm[n] > PM_MAX) ? PM_MAX[PM_W-1:0] : norm[n][PM_W-1:0];
    end
    best_n = 2'd0;
    for (int n = 1; n < 4; n++) begin
      if (new_pm[n] < new_pm[best_n]) best_n = 2'(n);
    end
  end

  always_comb begin
    pm_d        = pm_q;
    dec_d       = dec_q;
    best_d      = best_q;
    dec_valid_d = 1'b0;
    cnt_d       = cnt_q;
    rdy_d       = rdy_q;
    if (bus.start) begin
      pm_d[0] = '0;
      pm_d[1] = PM_INIT;
      pm_d[2] = PM_INIT;
      pm_d[3] = PM_INIT;
      dec_d   = '0;
      best_d  = '0;
      cnt_d   = '0;
      rdy_d   = 1'b0;
    end else if (bus.bm_valid) begin
      pm_d        = new_pm;
      dec_d       = dec_acs;
      best_d      = best_n;
      dec_valid_d = 1'b1;
      cnt_d       = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + 1'b1;
      rdy_d       = (cnt_d == CNT_TOP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q[0]     <= '0;
      pm_q[1]     <= PM_INIT;
      pm_q[2]     <= PM_INIT;
      pm_q[3]     <= PM_INIT;
      dec_q       <= '0;
      dec_valid_q <= 1'b0;
      best_q      <= '0;
      cnt_q       <= '0;
      rdy_q       <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      dec_q       <= dec_d;
      dec_valid_q <= dec_valid_d;
      best_q      <= best_d;
      cnt_q       <= cnt_d;
      rdy_q       <= rdy_d;
    end
  end

  assign bus.pm0        = pm_q[0];
  assign bus.pm1        = pm_q[1];
  assign bus.pm2        = pm_q[2];
  assign bus.pm3        = pm_q[3];
  assign bus.dec        = dec_q;
  assign bus.dec_valid  = dec_valid_q;
  assign bus.best_state = best_q;
  assign bus.tb_ready   = rdy_q;
endmodule

// File: doc/pmu_acs.md
Name: pmu_acs

Overview:
- Path metric unit for the 4-state, rate-1/2 (K=3) Viterbi decoder; sits directly downstream of the branch metric unit.
- Each step it consumes the eight 2-bit branch metrics (s0_00 … s3_11), runs add-compare-select for all four states and registers the new path metrics.
- Emits one survivor decision bit per state to the survivor memory unit, plus the best state and a traceback-ready flag.

Parameters:
- PM_W, 4, path metric width in bits (unsigned).
- INIT_PM, 4, initial metric of states 1..3 at reset/start; state 0 starts at 0.
- TB_DEPTH, 15, number of accepted steps before tb_ready asserts.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  synchronous frame restart; reinitialises metrics and step counter.
- bm_valid  in  1  branch metrics valid this cycle; one trellis step per valid cycle.
- s0_00, s0_01, s1_10, s1_11, s2_00, s2_01, s3_10, s3_11  in  2 each  branch metrics; sX_YZ = cost of the branch from state X to state YZ.
- dec  out  4  survivor decisions, bit n for state n.
- dec_valid  out  1  dec/pm/best_state updated by the previous cycle's step.
- pm0, pm1, pm2, pm3  out  PM_W each  registered path metrics.
- best_state  out  2  index of the minimum path metric.
- tb_ready  out  1  at least TB_DEPTH steps accepted since reset/start.

Behaviour:
- Reset (rst_n=0, async) sets:
  - pm0=0; pm1=pm2=pm3=INIT_PM.
  - dec=0, dec_valid=0, best_state=0, tb_ready=0, step count=0.
- Trellis predecessors (lower / upper):
  - state0: 0 via s0_00, 2 via s2_00.
  - state1: 0 via s0_01, 2 via s2_01.
  - state2: 1 via s1_10, 3 via s3_10.
  - state3: 1 via s1_11, 3 via s3_11.
- ACS on a clock edge with bm_valid=1:
  - cand_lo = pm[lower] + bm_lo; cand_hi = pm[upper] + bm_hi.
  - Sums are computed at PM_W+1 bits.
  - If cand_hi < cand_lo, select hi and set dec[n]=1; otherwise select lo and set dec[n]=0. Ties pick the lower-numbered predecessor.
- Post-processing of the four selected sums follows the optional feature below. Final metrics are clamped to 2^PM_W-1.
- Latency: one cycle.
  - Metrics sampled at edge k appear on dec, pm*, best_state after edge k.
  - dec_valid=1 for exactly that cycle.
- With bm_valid=0: metrics, dec and best_state hold; dec_valid=0.
- best_state = argmin of the new metrics; ties go to the lowest index.
- Step counter:
  - Increments on every accepted step and saturates at TB_DEPTH.
  - tb_ready = (count == TB_DEPTH), registered.
- start=1 has priority over bm_valid:
  - Metrics return to their reset values; count=0, tb_ready=0, dec=0, best_state=0, dec_valid=0.
  - Branch metrics presented in the same cycle are discarded.
- Reset asserted mid-frame: all state is lost immediately; the next step after release behaves as the first step of a frame.

Optional Feature:
- Macro: PMU_NORM_EN.
- Defined: after ACS, the minimum of the four selected sums is subtracted from all four before the clamp, so the minimum metric is always 0 after a step. The clamp stays in place as a safety net.
- Undefined: no normalisation; each metric saturates at 2^PM_W-1 and holds there.
- The reset value, start value and ACS decisions are unaffected by the macro.

Test Plan:
- Reset: hold rst_n=0, release -> pm=(0,4,4,4), dec=0, dec_valid=0, tb_ready=0, best_state=0.
- Single step with bm (s0_00,s0_01,s1_10,s1_11,s2_00,s2_01,s3_10,s3_11)=(0,2,1,1,2,0,1,1) -> next cycle: pm=(0,2,5,5), dec=4'b0000, best_state=0, dec_valid=1 for one cycle.
- Upper-predecessor win from reset, bm=(0,0,0,2,0,0,0,0) -> pm=(0,0,4,4), dec=4'b1000.
- Uniform-cost steps from reset, all bm=2:
  - With PMU_NORM_EN: pm=(0,0,4,4).
  - Without PMU_NORM_EN: pm=(2,2,6,6).
  - Keep feeding all bm=2 without the macro -> pm0 clamps at 15 and holds.
- Counter, start and reset-recovery:
  - 15 valid steps -> tb_ready rises after the 15th edge.
  - bm_valid=0 gaps do not advance the count.
  - start together with bm_valid -> pm=(0,4,4,4), tb_ready=0, dec_valid=0.
  - Async rst_n pulse between edges -> outputs reset immediately, without waiting for a clock edge.
